wb_burst_ram_slave: RTL

- Wishbone B3 responder for the SoC's external bus: the target that answers the CPU's external (non-peripheral) requests on the O_WB_* port.
- Backed by an inferred synchronous word RAM with a programmable initial-access wait state count.
- Supports classic single cycles and linear incrementing bursts (CTI 3'b010, end-of-burst 3'b111).
- Used as the main memory model in the SoC testbench and as a synthesizable on-chip RAM.

---
 rtl/wb_burst_ram_slave.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/wb_burst_ram_slave.sv
// Wishbone B3 burst-capable RAM responder: classic cycles and linear incrementing
// bursts with a programmable initial-access wait state count.
module wb_burst_ram_slave #(
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned WAIT_STATES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic [31:0] i_wb_adr,
    input  logic        i_wb_we,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_dat,
    input  logic [2:0]  i_wb_cti,
    input  logic [1:0]  i_wb_bte,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_wb_err
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_ACK1  = 3'd2;
    localparam logic [2:0] S_BURST = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [2:0]        CTI_INCR = 3'b010;
    localparam logic [3:0]        WS_L     = 4'(WAIT_STATES);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [31:0]       mem [0:DEPTH-1];

    logic [2:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              burst_q, burst_d;
    logic              we_q, we_d;
    logic [31:0]       dat_q;

    logic              ack_s;
    logic              wr_en_s;
    logic              rd_en_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [ADDR_W-1:0] adr_word_s;
    logic              unused_s;

    assign adr_word_s = i_wb_adr[ADDR_W+1:2];
    assign unused_s   = ^{i_wb_adr[31:ADDR_W+2], i_wb_adr[1:0]};

    // Responses are gated by cyc so a dropped cycle never sees ack/err or commits a write.
    assign ack_s    = i_wb_cyc & ((state_q == S_ACK1) | ((state_q == S_BURST) & i_wb_stb));
    assign wr_en_s  = ack_s & i_wb_we;
    assign o_wb_ack = ack_s;
    assign o_wb_err = i_wb_cyc & (state_q == S_ERR);
    assign o_wb_dat = dat_q;

    // Next-state logic; every read is issued one cycle ahead of the ack that presents it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        burst_d   = burst_q;
        we_d      = we_q;
        rd_en_s   = 1'b0;
        rd_addr_s = addr_q;
        case (state_q)
            S_IDLE: begin
                if (i_wb_cyc && i_wb_stb) begin
                    if ((i_wb_cti == CTI_INCR) && (i_wb_bte != 2'b00)) begin
                        state_d = S_ERR;
                    end else begin
                        addr_d  = adr_word_s;
                        burst_d = (i_wb_cti == CTI_INCR);
                        we_d    = i_wb_we;
                        cnt_d   = WS_L;
                        if (WS_L == 4'd0) begin
                            state_d   = S_ACK1;
                            rd_en_s   = ~i_wb_we;
                            rd_addr_s = adr_word_s;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!i_wb_cyc) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = S_ACK1;
                        rd_en_s = ~we_q;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_ACK1: begin
                if (i_wb_cyc && burst_q && (i_wb_cti == CTI_INCR)) begin
                    state_d   = S_BURST;
                    addr_d    = addr_q + ADDR_ONE;
                    rd_en_s   = ~i_wb_we;
                    rd_addr_s = addr_q + ADDR_ONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BURST: begin
                if (!i_wb_cyc) begin
                    state_d = S_IDLE;
                end else if (i_wb_stb) begin
                    if (i_wb_cti == CTI_INCR) begin
                        state_d   = S_BURST;
                        addr_d    = addr_q + ADDR_ONE;
                        rd_en_s   = ~i_wb_we;
                        rd_addr_s = addr_q + ADDR_ONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_BURST;
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= {ADDR_W{1'b0}};
            burst_q <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            we_q    <= we_d;
        end
    end

    // Registered read port; holds its value whenever no read is issued.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dat_q <= 32'd0;
        end else if (rd_en_s) begin
            dat_q <= mem[rd_addr_s];
        end else begin
            dat_q <= dat_q;
        end
    end

    // Byte-lane write port; contents survive reset.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en_s && i_wb_sel[b]) begin
                mem[addr_q][8*b +: 8] <= i_wb_dat[8*b +: 8];
            end
        end
    end

endmodule
